bmp_loader: RTL and testbench



---
 rtl/bmp_loader.sv | 126 ++++++++++++
 tb/tb_bmp_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bmp_loader.sv
// Bitmap loader: fetches ROWS rows of WIDTH bits from a narrow memory port,
// packs them into one wide image and hands it to the consumer with a wren strobe.
module bmp_loader #(
    parameter int ROWS   = 64,
    parameter int WIDTH  = 24,
    parameter int ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic                    consumer_ready,
    output logic                    mem_rd,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [WIDTH-1:0]        mem_rdata,
    input  logic                    mem_valid,
    output logic [ROWS*WIDTH-1:0]   bmpout,
    output logic                    wren,
    output logic                    busy,
    output logic                    done
);

    localparam int CNT_W = $clog2(ROWS) + 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        LOAD = 2'd3
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        row_cnt_r;
    logic [ADDR_W-1:0]       addr_r;
    logic [ROWS*WIDTH-1:0]   bmp_r;
    logic                    mem_rd_r;
    logic                    wren_r;
    logic                    busy_r;
    logic                    accept_s;

    // A row is taken only while reading; mem_valid elsewhere is ignored.
    assign accept_s = (state_r == READ) && mem_valid;

    // Control FSM: sequencing, row counter, address pointer and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            row_cnt_r <= {CNT_W{1'b0}};
            addr_r    <= {ADDR_W{1'b0}};
            mem_rd_r  <= 1'b0;
            wren_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    wren_r <= 1'b0;
                    if (start) begin
                        state_r   <= READ;
                        addr_r    <= base_addr;
                        row_cnt_r <= {CNT_W{1'b0}};
                        mem_rd_r  <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        mem_rd_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                READ: begin
                    if (accept_s) begin
                        row_cnt_r <= row_cnt_r + CNT_W'(1);
                        addr_r    <= addr_r + ADDR_W'(1);
                        if (row_cnt_r == LAST_ROW) begin
                            state_r  <= HOLD;
                            mem_rd_r <= 1'b0;
                        end else begin
                            mem_rd_r <= 1'b1;
                        end
                    end else begin
                        mem_rd_r <= 1'b1;
                    end
                end
                HOLD: begin
                    mem_rd_r <= 1'b0;
                    if (consumer_ready) begin
                        state_r <= LOAD;
                        wren_r  <= 1'b1;
                    end else begin
                        wren_r <= 1'b0;
                    end
                end
                LOAD: begin
                    state_r  <= IDLE;
                    wren_r   <= 1'b0;
                    busy_r   <= 1'b0;
                    mem_rd_r <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    mem_rd_r <= 1'b0;
                    wren_r   <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    // Image register: untouched rows keep the previous image, it is never cleared on start.
    always_ff @(posedge clk) begin
        if (rst) begin
            bmp_r <= {(ROWS*WIDTH){1'b0}};
        end else if (accept_s) begin
            bmp_r[int'(row_cnt_r)*WIDTH +: WIDTH] <= mem_rdata;
        end else begin
            bmp_r <= bmp_r;
        end
    end

    assign mem_rd   = mem_rd_r;
    assign mem_addr = addr_r;
    assign bmpout   = bmp_r;
    assign wren     = wren_r;
    assign done     = wren_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_bmp_loader.sv
// Scoreboard bench for bmp_loader: expected addresses and images are queued at
// stimulus time and consumed by a monitor whenever the DUT presents them.
module tb_bmp_loader;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   base_addr;
    logic          consumer_ready;
    logic          mem_rd;
    logic [15:0]   mem_addr;
    logic [23:0]   mem_rdata;
    logic          mem_valid;
    logic [1535:0] bmpout;
    logic          wren;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    logic          prev_wren = 1'b0;
    logic [15:0]   addr_q[$];
    logic [1535:0] img_q[$];
    logic [1535:0] model_img = '0;

    bmp_loader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .consumer_ready(consumer_ready), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .bmpout(bmpout),
        .wren(wren), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pat(input logic [7:0] tag, input int r);
        return {tag, 16'(r)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_img(input string name, input logic [1535:0] act, input logic [1535:0] exp);
        int bad;
        checks++;
        if (act !== exp) begin
            errors++;
            bad = 0;
            for (int r = 63; r >= 0; r--)
                if (act[r*24 +: 24] !== exp[r*24 +: 24]) bad = r;
            $display("FAIL %s: row %0d got %06h expected %06h", name, bad,
                     act[bad*24 +: 24], exp[bad*24 +: 24]);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("done_eq_wren", 32'(done), 32'(wren));
                if (wren) begin
                    chk("wren_not_back_to_back", 32'(prev_wren), 32'd0);
                    if (img_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wren_unexpected: got wren=1 expected no load pending");
                    end else begin
                        chk_img("load_image", bmpout, img_q.pop_front());
                    end
                end
                if (mem_rd) begin
                    if (addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_rd_unexpected: got addr %04h expected no read", mem_addr);
                    end else begin
                        chk("mem_addr", 32'(mem_addr), 32'(addr_q[0]));
                        if (mem_valid) void'(addr_q.pop_front());
                    end
                end
            end
            prev_wren = wren;
        end
    endtask

    // One bitmap load; abort_row >= 0 resets mid-load, glitch_cyc pulses start in READ.
    task automatic do_load(input logic [15:0] base, input logic [7:0] tag, input int stall,
                           input int ready_delay, input int abort_row, input int glitch_cyc);
        int cyc, acc, guard, wcyc, hold_cyc;
        logic [1535:0] img;
        img = model_img;
        for (int r = 0; r < 64; r++) begin
            addr_q.push_back(base + 16'(r));
            img[r*24 +: 24] = pat(tag, r);
        end
        img_q.push_back(img);
        base_addr = base;
        start = 1'b1;
        consumer_ready = (ready_delay == 0);
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = ~base;
        cyc = 1; acc = 0; guard = 0;
        while (acc < 64 && guard < 2000 && acc != abort_row) begin
            start = (cyc == glitch_cyc);
            mem_valid = ((cyc % stall) == 0);
            mem_rdata = pat(tag, acc);
            consumer_ready = (ready_delay == 0) ? 1'b1 : cyc[0];
            @(negedge clk);
            if (mem_rd && mem_valid) acc++;
            @(posedge clk); #1;
            cyc++; guard++;
        end
        start = 1'b0;
        mem_valid = 1'b0;
        if (guard >= 2000) chk("read_phase_timeout", 32'(acc), 32'd64);
        if (abort_row >= 0) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            addr_q.delete();
            img_q.delete();
            model_img = '0;
            chk("rst_mem_rd", 32'(mem_rd), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_wren", 32'(wren), 32'd0);
            chk_img("rst_bmpout", bmpout, '0);
            repeat (6) begin
                @(negedge clk);
                chk("no_wren_after_abort", 32'(wren), 32'd0);
            end
            @(posedge clk); #1;
        end else begin
            chk("hold_mem_rd", 32'(mem_rd), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
            if (stall == 1) chk("hold_entry_cycle", 32'(cyc), 32'd65);
            hold_cyc = cyc;
            wcyc = -1;
            for (int k = 0; k < ready_delay + 5 && wcyc < 0; k++) begin
                consumer_ready = (k >= ready_delay);
                @(negedge clk);
                if (wren) begin
                    wcyc = cyc;
                end else if (k < ready_delay) begin
                    chk("bp_busy", 32'(busy), 32'd1);
                    chk("bp_mem_rd", 32'(mem_rd), 32'd0);
                    chk_img("bp_bmpout_stable", bmpout, img);
                end
                @(posedge clk); #1;
                cyc++;
            end
            chk("wren_cycle", 32'(wcyc), 32'(hold_cyc + ready_delay + 1));
            chk("busy_after_load", 32'(busy), 32'd0);
            chk("wren_after_load", 32'(wren), 32'd0);
            model_img = img;
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        rst = 1'b1; start = 1'b0; base_addr = 16'h0000; consumer_ready = 1'b0;
        mem_rdata = 24'h000000; mem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_mem_rd", 32'(mem_rd), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_wren", 32'(wren), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk_img("reset_bmpout", bmpout, '0);

        // basic load
        do_load(16'h0100, 8'h00, 1, 0, -1, -1);
        chk("basic_row0", 32'(bmpout[23:0]), 32'h0);
        chk("basic_row63", 32'(bmpout[1535:1512]), 32'h3F);

        // mem_valid in IDLE must not disturb the image
        mem_rdata = 24'hFFFFFF;
        mem_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_valid = 1'b0;
        chk_img("idle_valid_ignored", bmpout, model_img);
        chk("idle_busy", 32'(busy), 32'd0);

        // stalled memory, same image as basic load
        do_load(16'h0100, 8'h00, 3, 0, -1, -1);
        chk("stall_row63", 32'(bmpout[1535:1512]), 32'h3F);

        // address wrap
        do_load(16'hFFF0, 8'h5A, 1, 0, -1, -1);
        chk("wrap_row16", 32'(bmpout[16*24 +: 24]), 32'h5A0010);

        // back-pressure with consumer_ready toggling during READ
        do_load(16'h2000, 8'h33, 1, 20, -1, -1);

        // start pulsed mid-READ is ignored
        do_load(16'h0300, 8'h11, 1, 0, -1, 10);

        // reset at row 30, then a fresh load
        do_load(16'h0400, 8'h77, 1, 0, 30, -1);
        do_load(16'h0500, 8'h66, 2, 0, -1, -1);

        repeat (3) @(posedge clk);
        #1;
        chk("addr_queue_drained", 32'(addr_q.size()), 32'd0);
        chk("img_queue_drained", 32'(img_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
